step_dir_decoder: RTL and testbench

- Receive side of the STEP/DIR interface used by the stepper driver path. Accepts asynchronous STEP and DIR lines, synchronises them, and validates pulse width and direction setup.
- Each valid step pulse updates a signed absolute position counter.
- Used by the plotter top level for axis position tracking: loopback of generated step clocks, or monitoring of an external controller. Reports target arrival and protocol errors.

---
 rtl/step_dir_decoder.sv | 158 +++++++++++++++
 tb/tb_step_dir_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_decoder.sv
// STEP/DIR receiver: synchronises the lines, validates pulse width and DIR setup,
// and tracks a signed absolute position with target and idle reporting.
module step_dir_decoder #(
  parameter int unsigned POS_WIDTH    = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MIN_HIGH     = 50,
  parameter int unsigned DIR_SETUP    = 10,
  parameter int unsigned IDLE_TIMEOUT = 2500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_in,
  input  logic                 dir_in,
  input  logic                 clear,
  input  logic                 load_en,
  input  logic [POS_WIDTH-1:0] load_value,
  input  logic [POS_WIDTH-1:0] target,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_strobe,
  output logic                 moving,
  output logic                 at_target,
  output logic                 err_short,
  output logic                 err_dir
);

  localparam int unsigned WidthW = $clog2(MIN_HIGH + 1);
  localparam int unsigned SetupW = $clog2(DIR_SETUP + 1);
  localparam int unsigned IdleW  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {StLow, StHigh, StCommit} state_e;

  logic [SYNC_STAGES-1:0] step_sync_q, dir_sync_q;
  logic                   s_step, s_dir, step_prev_q, dir_prev_q;
  logic                   step_rise, step_fall, dir_change;
  logic [SetupW-1:0]      dir_stable_q, dir_stable_d;
  state_e                 state_q, state_d;
  logic [WidthW-1:0]      width_q, width_d;
  logic                   dir_latched_q, dir_latched_d;
  logic [POS_WIDTH-1:0]   position_q, position_d;
  logic                   strobe_q, moving_q, moving_d, at_target_q;
  logic [IdleW-1:0]       idle_q, idle_d;
  logic                   err_short_q, err_short_d, err_dir_q, err_dir_d;
  logic                   commit, short_evt, dir_evt;

  assign s_step     = step_sync_q[SYNC_STAGES-1];
  assign s_dir      = dir_sync_q[SYNC_STAGES-1];
  assign step_rise  = s_step & ~step_prev_q;
  assign step_fall  = ~s_step & step_prev_q;
  assign dir_change = s_dir ^ dir_prev_q;

  always_comb begin
    state_d       = state_q;
    width_d       = width_q;
    dir_latched_d = dir_latched_q;
    commit        = 1'b0;
    short_evt     = 1'b0;
    dir_evt       = 1'b0;
    unique case (state_q)
      StHigh: begin
        if (dir_change) dir_evt = 1'b1;
        if (step_fall) begin
          if (width_q >= WidthW'(MIN_HIGH)) begin
            state_d = StCommit;
          end else begin
            short_evt = 1'b1;
            state_d   = StLow;
          end
        end else if (width_q < WidthW'(MIN_HIGH)) begin
          width_d = width_q + WidthW'(1);
        end
      end
      StCommit: commit = 1'b1;
      default: ;
    endcase
    // A rising edge in the commit cycle starts the next pulse immediately.
    if (state_q != StHigh && step_rise) begin
      state_d       = StHigh;
      dir_latched_d = s_dir;
      width_d       = WidthW'(1);
      if (dir_stable_q < SetupW'(DIR_SETUP) || dir_change) dir_evt = 1'b1;
    end else if (state_q == StCommit) begin
      state_d = StLow;
    end
  end

  always_comb begin
    if (clear)        position_d = '0;
    else if (load_en) position_d = load_value;
    else if (commit)  position_d = dir_latched_q ? position_q + POS_WIDTH'(1)
                                                 : position_q - POS_WIDTH'(1);
    else              position_d = position_q;

    err_short_d = short_evt | (err_short_q & ~clear);
    err_dir_d   = dir_evt | (err_dir_q & ~clear);

    if (dir_change)                          dir_stable_d = '0;
    else if (dir_stable_q < SetupW'(DIR_SETUP)) dir_stable_d = dir_stable_q + SetupW'(1);
    else                                     dir_stable_d = dir_stable_q;

    moving_d = moving_q;
    idle_d   = idle_q;
    if (commit) begin
      moving_d = 1'b1;
      idle_d   = '0;
    end else if (moving_q) begin
      if (idle_q == IdleW'(IDLE_TIMEOUT - 1)) begin
        moving_d = 1'b0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_sync_q   <= '0;
      dir_sync_q    <= '0;
      step_prev_q   <= 1'b0;
      dir_prev_q    <= 1'b0;
      dir_stable_q  <= '0;
      state_q       <= StLow;
      width_q       <= '0;
      dir_latched_q <= 1'b0;
      position_q    <= '0;
      strobe_q      <= 1'b0;
      moving_q      <= 1'b0;
      idle_q        <= '0;
      at_target_q   <= 1'b0;
      err_short_q   <= 1'b0;
      err_dir_q     <= 1'b0;
    end else begin
      step_sync_q   <= {step_sync_q[SYNC_STAGES-2:0], step_in};
      dir_sync_q    <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
      step_prev_q   <= s_step;
      dir_prev_q    <= s_dir;
      dir_stable_q  <= dir_stable_d;
      state_q       <= state_d;
      width_q       <= width_d;
      dir_latched_q <= dir_latched_d;
      position_q    <= position_d;
      strobe_q      <= commit;
      moving_q      <= moving_d;
      idle_q        <= idle_d;
      at_target_q   <= (position_d == target);
      err_short_q   <= err_short_d;
      err_dir_q     <= err_dir_d;
    end
  end

  assign position    = position_q;
  assign step_strobe = strobe_q;
  assign moving      = moving_q;
  assign at_target   = at_target_q;
  assign err_short   = err_short_q;
  assign err_dir     = err_dir_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Self-checking bench for step_dir_decoder: scoreboard of expected commits
// (position and strobe cycle) plus per-scenario inline checks.
module tb_step_dir_decoder;

  localparam int unsigned IdleT = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_in = 1'b0;
  logic        dir_in = 1'b0;
  logic        clear = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_value = '0;
  logic [31:0] target = '0;
  logic [31:0] position;
  logic        step_strobe, moving, at_target, err_short, err_dir;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  logic [31:0] exp_pos = '0;
  logic [31:0] pos_q[$];
  int          cyc_q[$];

  step_dir_decoder #(
    .POS_WIDTH   (32),
    .SYNC_STAGES (2),
    .MIN_HIGH    (50),
    .DIR_SETUP   (10),
    .IDLE_TIMEOUT(IdleT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step_in    (step_in),
    .dir_in     (dir_in),
    .clear      (clear),
    .load_en    (load_en),
    .load_value (load_value),
    .target     (target),
    .position   (position),
    .step_strobe(step_strobe),
    .moving     (moving),
    .at_target  (at_target),
    .err_short  (err_short),
    .err_dir    (err_dir)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (!reset && step_strobe) begin
      n_total++;
      if (pos_q.size() == 0) begin
        $display("FAIL strobe_unexpected: got strobe at cycle %0d position %h, none expected",
                 cyc, position);
      end else begin
        logic [31:0] p;
        int          c;
        p = pos_q.pop_front();
        c = cyc_q.pop_front();
        if (position !== p || cyc !== c)
          $display("FAIL commit: got position %h at cycle %0d, expected %h at cycle %0d",
                   position, cyc, p, c);
        else n_pass++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo, input bit counts, input bit up);
    step_in = 1'b1;
    tick(hi);
    step_in = 1'b0;
    if (counts) begin
      exp_pos = up ? exp_pos + 32'd1 : exp_pos - 32'd1;
      pos_q.push_back(exp_pos);
      cyc_q.push_back(cyc + 4);
    end
    tick(lo);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_pos = '0;
    tick(1);
  endtask

  task automatic check_drained(input string name);
    n_total++;
    if (pos_q.size() != 0)
      $display("FAIL %s_drained: %0d expected commits never seen, expected 0", name, pos_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    tick(3);
    n_total++;
    if (position !== 32'd0 || step_strobe !== 1'b0 || moving !== 1'b0 || at_target !== 1'b0 ||
        err_short !== 1'b0 || err_dir !== 1'b0)
      $display("FAIL reset_state: got pos %h strb %b mov %b at %b es %b ed %b, expected all 0",
               position, step_strobe, moving, at_target, err_short, err_dir);
    else n_pass++;
    reset = 1'b0;
    tick(20);
    n_total++;
    if (at_target !== 1'b1) $display("FAIL reset_at_target: got %b expected 1", at_target);
    else n_pass++;
    // Reset in the middle of a pulse.
    step_in = 1'b1;
    tick(30);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    step_in = 1'b0;
    tick(20);
    n_total++;
    if (position !== 32'd0 || err_short !== 1'b0 || err_dir !== 1'b0)
      $display("FAIL reset_mid_pulse: got pos %h es %b ed %b, expected 0 0 0",
               position, err_short, err_dir);
    else n_pass++;
    check_drained("reset");
  endtask

  task automatic test_count();
    dir_in = 1'b1;
    tick(20);
    for (int i = 0; i < 5; i++) pulse(60, 60, 1'b1, 1'b1);
    n_total++;
    if (position !== 32'd5 || err_short !== 1'b0 || err_dir !== 1'b0 || moving !== 1'b1)
      $display("FAIL count_up: got pos %h es %b ed %b mov %b, expected 5 0 0 1",
               position, err_short, err_dir, moving);
    else n_pass++;
    dir_in = 1'b0;
    tick(20);
    for (int i = 0; i < 3; i++) pulse(60, 60, 1'b1, 1'b0);
    n_total++;
    if (position !== 32'd2) $display("FAIL count_down: got %h expected 2", position);
    else n_pass++;
    check_drained("count");
  endtask

  task automatic test_short();
    pulse(20, 60, 1'b0, 1'b0);
    n_total++;
    if (err_short !== 1'b1 || position !== 32'd2 || err_dir !== 1'b0)
      $display("FAIL short_pulse: got es %b pos %h ed %b, expected 1 2 0",
               err_short, position, err_dir);
    else n_pass++;
    do_clear();
    n_total++;
    if (err_short !== 1'b0 || position !== 32'd0)
      $display("FAIL short_clear: got es %b pos %h, expected 0 0", err_short, position);
    else n_pass++;
  endtask

  task automatic test_dir_err();
    dir_in = 1'b1;
    tick(3);
    pulse(60, 60, 1'b1, 1'b1);
    n_total++;
    if (err_dir !== 1'b1 || position !== 32'd1)
      $display("FAIL dir_setup: got ed %b pos %h, expected 1 1", err_dir, position);
    else n_pass++;
    do_clear();
    tick(20);
    step_in = 1'b1;
    tick(20);
    dir_in = 1'b0;
    tick(40);
    pulse(0, 60, 1'b1, 1'b1);
    n_total++;
    if (err_dir !== 1'b1 || position !== 32'd1 || err_short !== 1'b0)
      $display("FAIL dir_mid_high: got ed %b pos %h es %b, expected 1 1 0",
               err_dir, position, err_short);
    else n_pass++;
    do_clear();
    tick(20);
    check_drained("dir");
  endtask

  task automatic test_wrap();
    load_value = 32'h7FFF_FFFF;
    load_en = 1'b1;
    tick(1);
    load_en = 1'b0;
    exp_pos = 32'h7FFF_FFFF;
    dir_in = 1'b1;
    tick(20);
    pulse(60, 60, 1'b1, 1'b1);
    n_total++;
    if (position !== 32'h8000_0000) $display("FAIL wrap_up: got %h expected 80000000", position);
    else n_pass++;
    load_value = 32'h0;
    load_en = 1'b1;
    tick(1);
    load_en = 1'b0;
    exp_pos = 32'h0;
    dir_in = 1'b0;
    tick(20);
    pulse(60, 60, 1'b1, 1'b0);
    n_total++;
    if (position !== 32'hFFFF_FFFF || err_dir !== 1'b0 || err_short !== 1'b0)
      $display("FAIL wrap_down: got %h ed %b es %b, expected ffffffff 0 0",
               position, err_dir, err_short);
    else n_pass++;
    check_drained("wrap");
  endtask

  task automatic test_back_to_back();
    pulse(60, 1, 1'b1, 1'b0);
    pulse(60, 60, 1'b1, 1'b0);
    n_total++;
    if (position !== 32'hFFFF_FFFD || err_short !== 1'b0 || err_dir !== 1'b0)
      $display("FAIL back_to_back: got %h es %b ed %b, expected fffffffd 0 0",
               position, err_short, err_dir);
    else n_pass++;
    check_drained("b2b");
  endtask

  task automatic test_target_idle();
    int f;
    int guard;
    do_clear();
    target = 32'd3;
    dir_in = 1'b1;
    tick(20);
    n_total++;
    if (at_target !== 1'b0) $display("FAIL target_before: got %b expected 0", at_target);
    else n_pass++;
    pulse(60, 60, 1'b1, 1'b1);
    pulse(60, 60, 1'b1, 1'b1);
    step_in = 1'b1;
    tick(60);
    step_in = 1'b0;
    exp_pos = exp_pos + 32'd1;
    pos_q.push_back(exp_pos);
    f = cyc;
    cyc_q.push_back(f + 4);
    tick(3);
    n_total++;
    if (at_target !== 1'b0) $display("FAIL target_early: got %b expected 0", at_target);
    else n_pass++;
    tick(1);
    n_total++;
    if (at_target !== 1'b1 || step_strobe !== 1'b1)
      $display("FAIL target_commit: got at %b strb %b, expected 1 1", at_target, step_strobe);
    else n_pass++;
    guard = 0;
    while (moving === 1'b1 && guard < IdleT + 50) begin
      tick(1);
      guard++;
    end
    n_total++;
    if (cyc - (f + 4) != IdleT)
      $display("FAIL idle_timeout: moving fell %0d cycles after commit, expected %0d",
               cyc - (f + 4), IdleT);
    else n_pass++;
    check_drained("target");
  endtask

  initial begin
    test_reset();
    test_count();
    test_short();
    test_dir_err();
    test_wrap();
    test_back_to_back();
    test_target_idle();
    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
